// File: rtl/core_pkg.sv
// Shared types and constants for the core fetch path.
`default_nettype none

package core_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] FETCH_INCR = 32'd4;

endpackage

`default_nettype wire

// File: rtl/core_fetch_fifo.sv
// core_fetch_fifo: generic synchronous FIFO with push/pop/flush, count, full/empty.
`default_nettype none

module core_fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [63:0]
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  output T                           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T               mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]  count_q;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage carries no reset; consumers gate it with empty_o.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/core_prefetch.sv
// core_prefetch: multi-outstanding instruction prefetch with redirect discard.
// Optional zero-latency empty-FIFO bypass: define CORE_PREFETCH_BYPASS_EN.
`default_nettype none

module core_prefetch
  import core_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        arst_ni,
  output logic        inst_req_o,
  input  logic        inst_grnt_i,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_data_i,
  input  logic        inst_valid_i,
  input  logic        flush_i,
  input  logic        branch_i,
  input  logic [31:0] branch_pc_i,
  input  logic        instr_ready_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  localparam int          OW     = $clog2(MAX_OUTSTANDING+1);
  localparam int          CW     = $clog2(FIFO_DEPTH+1);
  localparam logic [31:0] MAX_U  = MAX_OUTSTANDING;
  localparam logic [31:0] DEPTH_U = FIFO_DEPTH;

  logic          req_q, req_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic          pend_q, pend_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic [CW-1:0] count_d;

  logic          redirect, grant, hold, resp_keep, bypass, push, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  head;

  assign redirect  = flush_i | branch_i;
  assign grant     = req_q & inst_grnt_i;
  assign hold      = req_q & ~inst_grnt_i;
  assign resp_keep = inst_valid_i & (discard_q == '0) & ~redirect;

`ifdef CORE_PREFETCH_BYPASS_EN
  assign bypass = fifo_empty & resp_keep;
`else
  assign bypass = 1'b0;
`endif

  assign push = resp_keep & ~(bypass & instr_ready_i);
  assign pop  = ~fifo_empty & instr_ready_i & ~redirect;

  always_comb begin
    outstanding_d = outstanding_q + OW'(grant) - OW'(inst_valid_i);
    count_d       = redirect ? '0 : fifo_count + CW'(push) - CW'(pop);

    // Everything still in flight at a redirect is stale; a held request
    // is added when its grant finally arrives.
    discard_d = discard_q;
    if (redirect) begin
      discard_d = outstanding_d;
    end else begin
      if (inst_valid_i && (discard_q != '0)) discard_d = discard_d - OW'(1);
      if (grant && pend_q)                   discard_d = discard_d + OW'(1);
    end

    fetch_addr_d = fetch_addr_q;
    pend_d       = pend_q;
    pend_pc_d    = pend_pc_q;
    if (redirect) begin
      pend_d    = hold;
      pend_pc_d = branch_pc_i;
      if (!hold) fetch_addr_d = branch_pc_i;
    end else if (grant) begin
      pend_d       = 1'b0;
      fetch_addr_d = pend_q ? pend_pc_q : fetch_addr_q + FETCH_INCR;
    end

    req_d = hold |
            ((32'(outstanding_d) < MAX_U) &&
             (32'(outstanding_d) + 32'(count_d) < DEPTH_U) && !pend_d);

    if (redirect)       resp_pc_d = branch_pc_i;
    else if (resp_keep) resp_pc_d = resp_pc_q + FETCH_INCR;
    else                resp_pc_d = resp_pc_q;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      req_q         <= 1'b0;
      fetch_addr_q  <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      resp_pc_q     <= RESET_PC;
      pend_q        <= 1'b0;
      pend_pc_q     <= RESET_PC;
    end else begin
      req_q         <= req_d;
      fetch_addr_q  <= fetch_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      resp_pc_q     <= resp_pc_d;
      pend_q        <= pend_d;
      pend_pc_q     <= pend_pc_d;
    end
  end

  core_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .flush_i (redirect),
    .push_i  (push),
    .data_i  ('{instr: inst_data_i, pc: resp_pc_q}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (arst_ni) assert (redirect || !(push && fifo_full && !pop));
  end

  assign inst_req_o    = req_q;
  assign inst_addr_o   = fetch_addr_q;
  assign instr_valid_o = ~fifo_empty | bypass;
  assign instr_o       = ~fifo_empty ? head.instr : (bypass ? inst_data_i : 32'd0);
  assign instr_pc_o    = ~fifo_empty ? head.pc : resp_pc_q;

endmodule

`default_nettype wire
